// File: rtl/pwm_drive_gen_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
// Shared types and constants for the per-phase PWM drive generator.
//   drive_mode_t  : requested drive mode (COAST/DRIVE/BRAKE; encoding 3 = COAST)
//   drive_state_t : drive-mode FSM state
//   PWM_WIDTH     : default counter/duty width (period = 2**PWM_WIDTH clk)
// -----------------------------------------------------------------------------
package motor_pkg;

    localparam int PWM_WIDTH = 11;

    typedef enum logic [1:0] {
        COAST = 2'd0,
        DRIVE = 2'd1,
        BRAKE = 2'd2
    } drive_mode_t;

    typedef enum logic [1:0] {
        S_COAST = 2'd0,
        S_DRIVE = 2'd1,
        S_BRAKE = 2'd2,
        S_FAULT = 2'd3
    } drive_state_t;

    // Raw 2-bit request to a legal mode; the unused encoding 3 means COAST.
    function automatic drive_mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    decode_mode = DRIVE;
            2'd2:    decode_mode = BRAKE;
            default: decode_mode = COAST;
        endcase
    endfunction

    function automatic drive_state_t mode_to_state(input drive_mode_t m);
        case (m)
            DRIVE:   mode_to_state = S_DRIVE;
            BRAKE:   mode_to_state = S_BRAKE;
            default: mode_to_state = S_COAST;
        endcase
    endfunction

endpackage

// File: rtl/pwm_drive_gen_if.sv
// -----------------------------------------------------------------------------
// pwm_drive_gen_if
// Control/status bundle between the phase controller and pwm_drive_gen.
//   duty       : requested on-time in clk cycles
//   mode_req   : raw drive_mode_t request
//   ocp        : over-current trip, active-high
//   fault_clr  : one-cycle fault clear pulse
//   high_req   : high-side gate request
//   low_req    : low-side gate request
//   pwm_synch  : one-cycle pulse at the start of each period
//   fault      : latched over-current fault
// master = controller side, slave = pwm_drive_gen side.
// -----------------------------------------------------------------------------
interface pwm_drive_gen_if
    import motor_pkg::*;
    #(parameter int WIDTH = PWM_WIDTH);

    logic [WIDTH-1:0] duty;
    logic [1:0]       mode_req;
    logic             ocp;
    logic             fault_clr;
    logic             high_req;
    logic             low_req;
    logic             pwm_synch;
    logic             fault;

    modport master (
        output duty, mode_req, ocp, fault_clr,
        input  high_req, low_req, pwm_synch, fault
    );

    modport slave (
        input  duty, mode_req, ocp, fault_clr,
        output high_req, low_req, pwm_synch, fault
    );

endinterface

// File: rtl/pwm_drive_gen_cnt.sv
// -----------------------------------------------------------------------------
// pwm_period_cnt
// Free-running period counter with boundary decode, period sync pulse and the
// period-aligned duty shadow.
//   clk, rst_n : clock, async active-low reset
//   duty       : requested duty, sampled only at the period boundary
//   bnd        : combinational, high on the last cycle of the period
//   pwm_sig    : registered (cnt < duty_act)
//   pwm_synch  : registered bnd, i.e. high while cnt == 0 of a new period
// -----------------------------------------------------------------------------
module pwm_period_cnt
    import motor_pkg::*;
    #(parameter int WIDTH = PWM_WIDTH)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] duty,
    output logic             bnd,
    output logic             pwm_sig,
    output logic             pwm_synch
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_act;

    assign bnd = (cnt == '1);

    // NOTE: every register here gets an explicit reset value; the async reset
    // must force the whole period back to a known start without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            duty_act  <= '0;
            pwm_sig   <= 1'b0;
            pwm_synch <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others (pwm_sig sees the old cnt/duty_act).
            cnt       <= cnt + 1'b1;
            pwm_synch <= bnd;
            pwm_sig   <= (cnt < duty_act);
            if (bnd) begin
                duty_act <= duty;
            end
        end
    end

endmodule

// File: rtl/pwm_drive_gen.sv
// -----------------------------------------------------------------------------
// pwm_drive_gen
// Per-phase PWM source: turns duty + drive-mode request into complementary
// high/low gate requests for the downstream non-overlap stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : pwm_drive_gen_if.slave (duty, mode_req, ocp, fault_clr in;
//                high_req, low_req, pwm_synch, fault out)
// Owns the drive-mode FSM, the over-current fault latch and the output mux;
// the counter and duty shadow live in pwm_period_cnt.
// -----------------------------------------------------------------------------
module pwm_drive_gen
    import motor_pkg::*;
    #(parameter int WIDTH = PWM_WIDTH)
(
    input  logic              clk,
    input  logic              rst_n,
    pwm_drive_gen_if.slave    bus
);

    logic         bnd;
    logic         pwm_sig;
    drive_mode_t  mode_act;
    drive_state_t state;
    drive_state_t state_nxt;
    logic         high_nxt;
    logic         low_nxt;
    // Set when a fault is cleared: keep coasting until the next period
    // boundary so the bridge restarts cleanly at a period start.
    logic         resume_hold;

    pwm_period_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .duty      (bus.duty),
        .bnd       (bnd),
        .pwm_sig   (pwm_sig),
        .pwm_synch (bus.pwm_synch)
    );

    // NOTE: all outputs are assigned a default first so no path through the
    // block leaves them unassigned (which would infer a latch).
    always_comb begin
        state_nxt = state;
        high_nxt  = 1'b0;
        low_nxt   = 1'b0;

        // ocp wins over everything, including a simultaneous boundary or clear.
        if (bus.ocp) begin
            state_nxt = S_FAULT;
        end else if (state == S_FAULT) begin
            state_nxt = bus.fault_clr ? S_COAST : S_FAULT;
        end else if (resume_hold) begin
            state_nxt = S_COAST;
        end else begin
            state_nxt = mode_to_state(mode_act);
        end

        case (state_nxt)
            S_DRIVE: begin
                high_nxt = pwm_sig;
                low_nxt  = ~pwm_sig;
            end
            S_BRAKE: begin
                low_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_COAST;
            mode_act     <= COAST;
            resume_hold  <= 1'b0;
            bus.high_req <= 1'b0;
            bus.low_req  <= 1'b0;
            bus.fault    <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.high_req <= high_nxt;
            bus.low_req  <= low_nxt;
            bus.fault    <= (state_nxt == S_FAULT);

            if (bnd) begin
                mode_act <= decode_mode(bus.mode_req);
            end

            if (bnd) begin
                resume_hold <= 1'b0;
            end else if (state == S_FAULT && state_nxt == S_COAST) begin
                resume_hold <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_drive_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_drive_gen
// Self-checking bench for pwm_drive_gen. Per-period vectors are applied from a
// table; fault, mid-period change and reset corner cases are hand sequences.
// A bench-side counter tracks the expected period position.
// -----------------------------------------------------------------------------
module tb_pwm_drive_gen;
    import motor_pkg::*;

    localparam int W   = PWM_WIDTH;
    localparam int PER = 1 << W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pwm_drive_gen_if #(.WIDTH(W)) bus();

    pwm_drive_gen #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Expected counter position and cycles since reset release.
    int tcnt;
    int since_rst;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt      <= 0;
            since_rst <= 0;
        end else begin
            tcnt <= (tcnt + 1) % PER;
            if (since_rst < PER) since_rst <= since_rst + 1;
        end
    end

    // Every-cycle properties, summarised by checks at the end.
    int overlap_errs = 0;
    int synch_errs   = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.high_req && bus.low_req) overlap_errs <= overlap_errs + 1;
            if (bus.pwm_synch !== ((tcnt == 0) && (since_rst >= PER)))
                synch_errs <= synch_errs + 1;
        end
    end

    // Return at the next negedge where the expected counter equals v.
    task automatic wait_cnt(input int v);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tcnt != v && k < 2 * PER);
        if (tcnt != v) check("wait_cnt_timeout", tcnt, v);
    endtask

    // Count outputs over n samples, starting with the current one.
    task automatic measure(input int n, output int hi, output int lo, output int sy);
        hi = 0; lo = 0; sy = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            hi += int'(bus.high_req);
            lo += int'(bus.low_req);
            sy += int'(bus.pwm_synch);
        end
    endtask

    typedef struct {
        string      name;
        logic [W-1:0] duty;
        logic [1:0] mode;
        int         exp_hi;
        int         exp_lo;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int hi, lo, sy;

        vecs[0] = '{"drive_half",  11'h400, 2'd1, 1024, 1024};
        vecs[1] = '{"drive_zero",  11'h000, 2'd1,    0, 2048};
        vecs[2] = '{"drive_max",   11'h7FF, 2'd1, 2047,    1};
        vecs[3] = '{"drive_256",   11'h100, 2'd1,  256, 1792};
        vecs[4] = '{"brake",       11'h600, 2'd2,    0, 2048};
        vecs[5] = '{"coast",       11'h200, 2'd0,    0,    0};
        vecs[6] = '{"mode3_coast", 11'h300, 2'd3,    0,    0};
        vecs[7] = '{"drive_one",   11'h001, 2'd1,    1, 2047};

        bus.duty      = 11'h400;
        bus.mode_req  = DRIVE;
        bus.ocp       = 1'b0;
        bus.fault_clr = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({bus.high_req, bus.low_req, bus.pwm_synch, bus.fault}), 0);

        // Test 1: first period after reset coasts even though DRIVE is requested
        rst_n = 1'b1;
        measure(PER, hi, lo, sy);
        check("first_period_hi", hi, 0);
        check("first_period_lo", lo, 0);
        check("first_period_synch", sy, 0);

        // Table: each vector latches at a boundary, measured over the next period
        for (int v = 0; v < 8; v++) begin
            bus.duty     = vecs[v].duty;
            bus.mode_req = vecs[v].mode;
            wait_cnt(0);
            wait_cnt(8);
            measure(PER, hi, lo, sy);
            check({vecs[v].name, "_hi"}, hi, vecs[v].exp_hi);
            check({vecs[v].name, "_lo"}, lo, vecs[v].exp_lo);
            check({vecs[v].name, "_synch"}, sy, 1);
        end

        // Test 3: duty change mid-period only takes effect next period
        bus.duty = 11'h100;
        wait_cnt(0);
        wait_cnt(8);
        hi = 0;
        for (int i = 0; i < PER; i++) begin
            if (i > 0) @(negedge clk);
            hi += int'(bus.high_req);
            if (tcnt == 'h300) bus.duty = 11'h600;
        end
        check("duty_change_cur_period", hi, 256);
        wait_cnt(8);
        measure(PER, hi, lo, sy);
        check("duty_change_next_period", hi, 1536);

        // Test 4: DRIVE -> BRAKE requested mid-period
        wait_cnt('h200);
        bus.mode_req = BRAKE;
        wait_cnt('h201);
        measure(PER - 'h201, hi, lo, sy);
        check("brake_req_rest_hi", hi, 1025);
        check("brake_req_rest_lo", lo, 510);
        wait_cnt(0);
        measure(PER, hi, lo, sy);
        check("brake_period_hi", hi, 0);
        check("brake_period_lo", lo, PER);

        // Test 5: over-current during the DRIVE high phase
        bus.mode_req = DRIVE;
        bus.duty     = 11'h400;
        wait_cnt('h100);
        check("pre_ocp_hi_lo", int'({bus.high_req, bus.low_req}), 2);
        bus.ocp = 1'b1;
        @(negedge clk);
        bus.ocp = 1'b0;
        check("ocp_outputs_off", int'({bus.high_req, bus.low_req}), 0);
        check("ocp_fault_set", int'(bus.fault), 1);
        repeat (100) @(negedge clk);
        check("fault_held", int'({bus.fault, bus.high_req, bus.low_req}), 4);
        bus.ocp       = 1'b1;
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.ocp       = 1'b0;
        bus.fault_clr = 1'b0;
        check("ocp_and_clr_stays", int'(bus.fault), 1);
        wait_cnt('h300);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        check("fault_cleared", int'({bus.fault, bus.high_req, bus.low_req}), 0);
        wait_cnt('h302);
        measure(PER - 'h302, hi, lo, sy);
        check("post_clear_coast", hi + lo, 0);
        wait_cnt(8);
        measure(PER - 8, hi, lo, sy);
        check("resume_drive_hi", hi, 1018);
        check("resume_drive_lo", lo, 1022);

        // Test 6: asynchronous reset while high_req is active
        wait_cnt('h50);
        check("pre_reset_hi", int'(bus.high_req), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              int'({bus.high_req, bus.low_req, bus.pwm_synch, bus.fault}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        measure(PER, hi, lo, sy);
        check("post_reset_coast", hi + lo, 0);
        wait_cnt(8);
        measure(PER - 8, hi, lo, sy);
        check("post_reset_drive_hi", hi, 1018);
        check("post_reset_drive_lo", lo, 1022);

        @(negedge clk);
        check("no_overlap_cycles", overlap_errs, 0);
        check("synch_alignment_errs", synch_errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
